// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified memory data port between fetch (IF) and load/store (DM); ARB_STARVE_GUARD_EN adds an IF starvation guard
module mem_port_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_valid,
   input  logic [63:0] if_req_addr,
   output logic        if_req_ready,
   output logic        if_rsp_valid,
   output logic [31:0] if_rsp_data,
   input  logic        dm_req_valid,
   input  logic [63:0] dm_req_addr,
   input  logic [2:0]  dm_req_rd_ctrl,
   input  logic [2:0]  dm_req_wr_ctrl,
   input  logic [63:0] dm_req_wdata,
   output logic        dm_req_ready,
   output logic        dm_rsp_valid,
   output logic [63:0] dm_rsp_data,
   output logic [63:0] mem_addr,
   output logic [2:0]  mem_rd_ctrl,
   output logic [2:0]  mem_wr_ctrl,
   output logic [63:0] mem_din,
   input  logic [63:0] mem_dout
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;
   logic [1:0]  state_q, state_d;
   logic        is_if_q, is_if_d;
   logic [63:0] addr_q, addr_d;
   logic [2:0]  rd_q, rd_d;
   logic [2:0]  wr_q, wr_d;
   logic [63:0] wdata_q, wdata_d;
   logic        if_rsp_valid_q, dm_rsp_valid_q;
   logic [31:0] if_rsp_data_q;
   logic [63:0] dm_rsp_data_q;
   logic        free, pick_if, if_acc, dm_acc, acc, in_access, drive;
   logic [31:0] if_result;
   logic [63:0] dm_result;
   assign free      = !rst && (state_q != ACCESS);
   assign in_access = (state_q == ACCESS);
`ifdef ARB_STARVE_GUARD_EN
   logic [2:0] starve_q, starve_d;
   assign pick_if = !dm_req_valid || (if_req_valid && (starve_q == 3'(STARVE_MAX)));
   // count consecutive DM grants made while IF waits; any other grant clears it
   always_comb starve_d = !acc ? starve_q : (dm_acc && if_req_valid) ? starve_q + 3'd1 : 3'd0;
   // starve counter register
   always_ff @(posedge clk or posedge rst)
      if (rst) starve_q <= 3'd0;
      else     starve_q <= starve_d;
`else
   assign pick_if = !dm_req_valid;
`endif
   assign if_req_ready = free && pick_if;
   assign dm_req_ready = free && !pick_if;
   assign if_acc       = if_req_valid && if_req_ready;
   assign dm_acc       = dm_req_valid && dm_req_ready;
   assign acc          = if_acc || dm_acc;
   // next state and request capture; IF requests become a doubleword read
   always_comb begin
      state_d = in_access ? RESP : acc ? ACCESS : IDLE;
      is_if_d = acc ? if_acc : is_if_q;
      addr_d  = acc ? (if_acc ? if_req_addr : dm_req_addr) : addr_q;
      rd_d    = acc ? (if_acc ? 3'b101 : dm_req_rd_ctrl) : rd_q;
      wr_d    = acc ? (if_acc ? 3'b000 : dm_req_wr_ctrl) : wr_q;
      wdata_d = acc ? (if_acc ? 64'd0 : dm_req_wdata) : wdata_q;
   end
   // state and request registers; reset drops any in-flight access
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         is_if_q <= 1'b0;
         addr_q  <= 64'd0;
         rd_q    <= 3'd0;
         wr_q    <= 3'd0;
         wdata_q <= 64'd0;
      end else begin
         state_q <= state_d;
         is_if_q <= is_if_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
      end
   // memory port is driven only during ACCESS, and never for a DM no-op
   assign drive       = in_access && (is_if_q || (rd_q != 3'd0) || (wr_q != 3'd0));
   assign mem_addr    = drive ? (is_if_q ? {addr_q[63:3], 3'b000} : addr_q) : 64'd0;
   assign mem_rd_ctrl = drive ? rd_q : 3'd0;
   assign mem_wr_ctrl = drive ? wr_q : 3'd0;
   assign mem_din     = drive ? wdata_q : 64'd0;
   assign if_result   = (addr_q[1:0] != 2'd0) ? 32'd0 : addr_q[2] ? mem_dout[63:32] : mem_dout[31:0];
   assign dm_result   = ((rd_q != 3'd0) && (wr_q == 3'd0)) ? mem_dout : 64'd0;
   // capture the result at the edge ending ACCESS; data holds until the next response
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         if_rsp_valid_q <= 1'b0;
         dm_rsp_valid_q <= 1'b0;
         if_rsp_data_q  <= 32'd0;
         dm_rsp_data_q  <= 64'd0;
      end else begin
         if_rsp_valid_q <= in_access && is_if_q;
         dm_rsp_valid_q <= in_access && !is_if_q;
         if (in_access && is_if_q) if_rsp_data_q <= if_result;
         if (in_access && !is_if_q) dm_rsp_data_q <= dm_result;
      end
   assign if_rsp_valid = if_rsp_valid_q;
   assign dm_rsp_valid = dm_rsp_valid_q;
   assign if_rsp_data  = if_rsp_data_q;
   assign dm_rsp_data  = dm_rsp_data_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors, corner sequences and random traffic against a byte-level reference
module tb_mem_port_arbiter;
   localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif
   logic clk = 1'b0, rst;
   logic if_req_valid, if_req_ready, if_rsp_valid;
   logic [63:0] if_req_addr;
   logic [31:0] if_rsp_data;
   logic dm_req_valid, dm_req_ready, dm_rsp_valid;
   logic [63:0] dm_req_addr, dm_req_wdata, dm_rsp_data;
   logic [2:0] dm_req_rd_ctrl, dm_req_wr_ctrl;
   logic [63:0] mem_addr, mem_din, mem_dout;
   logic [2:0] mem_rd_ctrl, mem_wr_ctrl;
   int n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
      .dm_req_valid(dm_req_valid), .dm_req_addr(dm_req_addr), .dm_req_rd_ctrl(dm_req_rd_ctrl),
      .dm_req_wr_ctrl(dm_req_wr_ctrl), .dm_req_wdata(dm_req_wdata), .dm_req_ready(dm_req_ready),
      .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
      .mem_addr(mem_addr), .mem_rd_ctrl(mem_rd_ctrl), .mem_wr_ctrl(mem_wr_ctrl),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   // environment memory: 32 doublewords, combinational read, write on posedge
   logic [63:0] mem [0:31];
   logic preload = 1'b0;
   logic [31:0] seed = 32'd0;

   function automatic logic [63:0] pat(input logic [31:0] s, input int i);
      if (s == 32'd0) return (i == 1) ? 64'hAAAA_BBBB_1111_2222 : 64'd0;
      return {s ^ (32'(i) * 32'h9E37_79B9), (s + 32'(i)) * 32'h0100_0193};
   endfunction

   function automatic logic [63:0] mem_read(input logic [63:0] a, input logic [2:0] rd);
      logic [63:0] w;
      w = mem[a[7:3]] >> {a[2:0], 3'b000};
      case (rd)
         3'd1: return {{56{w[7]}}, w[7:0]};
         3'd2: return {56'd0, w[7:0]};
         3'd3: return {{48{w[15]}}, w[15:0]};
         3'd4: return {48'd0, w[15:0]};
         3'd5: return mem[a[7:3]];
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [63:0] wmerge(input logic [63:0] old, input logic [63:0] din,
                                          input logic [2:0] wr, input logic [2:0] off);
      logic [63:0] m;
      m = (wr == 3'd1) ? 64'hFF : (wr == 3'd2) ? 64'hFFFF : (wr == 3'd3) ? 64'hFFFF_FFFF : '1;
      m = m << {off, 3'b000};
      return (old & ~m) | ((din << {off, 3'b000}) & m);
   endfunction

   always_comb mem_dout = mem_read(mem_addr, mem_rd_ctrl);

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) mem[i] <= pat(seed, i);
      end else if (mem_wr_ctrl != 3'd0) begin
         mem[mem_addr[7:3]] <= wmerge(mem[mem_addr[7:3]], mem_din, mem_wr_ctrl, mem_addr[2:0]);
      end
   end

   // reference model: flat little-endian byte array
   logic [7:0] sh [0:255];

   task automatic sh_init(input logic [31:0] s);
      logic [63:0] w;
      for (int i = 0; i < 32; i++) begin
         w = pat(s, i);
         for (int b = 0; b < 8; b++) sh[i * 8 + b] = w[8 * b +: 8];
      end
   endtask

   function automatic logic [63:0] ref_if(input logic [7:0] a);
      logic [63:0] r;
      r = 64'd0;
      if (a[1:0] == 2'd0)
         for (int b = 0; b < 4; b++) r[8 * b +: 8] = sh[8'(int'(a) + b)];
      return r;
   endfunction

   task automatic ref_dm(input logic [7:0] a, input logic [2:0] rd, input logic [2:0] wr,
                         input logic [63:0] wd, output logic [63:0] r);
      int n;
      r = 64'd0;
      if (wr != 3'd0) begin
         n = (wr == 3'd1) ? 1 : (wr == 3'd2) ? 2 : (wr == 3'd3) ? 4 : 8;
         for (int b = 0; b < n; b++) sh[8'(int'(a) + b)] = wd[8 * b +: 8];
      end else begin
         n = (rd == 3'd1 || rd == 3'd2) ? 1 : (rd == 3'd3 || rd == 3'd4) ? 2 : (rd == 3'd5) ? 8 : 0;
         for (int b = 0; b < n; b++) r[8 * b +: 8] = sh[8'(int'(a) + b)];
         if (rd == 3'd1) r = {{56{r[7]}}, r[7:0]};
         if (rd == 3'd3) r = {{48{r[15]}}, r[15:0]};
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct {
      logic        is_dm;
      logic [63:0] addr;
      logic [2:0]  rd;
      logic [2:0]  wr;
      logic [63:0] wd;
      logic [63:0] exp;
   } vec_t;

   task automatic idle_inputs();
      if_req_valid = 1'b0; if_req_addr = 64'd0;
      dm_req_valid = 1'b0; dm_req_addr = 64'd0;
      dm_req_rd_ctrl = 3'd0; dm_req_wr_ctrl = 3'd0; dm_req_wdata = 64'd0;
   endtask

   // single transaction from IDLE: ready, ACCESS port values, latency and response data
   task automatic txn(input vec_t v, input string nm);
      int lat;
      logic noop;
      @(negedge clk);
      if_req_valid = !v.is_dm; if_req_addr = v.addr;
      dm_req_valid = v.is_dm; dm_req_addr = v.addr;
      dm_req_rd_ctrl = v.rd; dm_req_wr_ctrl = v.wr; dm_req_wdata = v.wd;
      #1 chk({nm, " ready"}, 64'(v.is_dm ? dm_req_ready : if_req_ready), 64'd1);
      @(negedge clk);
      idle_inputs();
      noop = v.is_dm && v.rd == 3'd0 && v.wr == 3'd0;
      chk({nm, " mem_addr"}, mem_addr, noop ? 64'd0 : v.is_dm ? v.addr : {v.addr[63:3], 3'b000});
      chk({nm, " mem_ctrl"}, 64'({mem_rd_ctrl, mem_wr_ctrl}), 64'(v.is_dm ? {v.rd, v.wr} : 6'b101_000));
      lat = 1;
      while (!(v.is_dm ? dm_rsp_valid : if_rsp_valid) && lat < 6) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, " latency"}, 64'(lat), 64'd2);
      chk({nm, " data"}, v.is_dm ? dm_rsp_data : {32'd0, if_rsp_data}, v.exp);
   endtask

   vec_t vecs [19];
   typedef struct {
      logic        is_if;
      logic [63:0] data;
      int          due;
   } pend_t;
   pend_t pq [$];
   logic e_if, e_dm, acc_prev, prev_is_if, a_if, a_dm, win_if, p_if_rdy, p_dm_rdy, drv;
   logic [63:0] prev_addr, prev_wd, hold_if, hold_dm, r, e_addr;
   logic [2:0] prev_rd, prev_wr, rdv, wrv;
   logic [7:0] a8;
   int op, al, starve, slots, if_slot;
   logic [63:0] p_val;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b0, 64'h8,  3'd0, 3'd0, 64'd0, 64'h1111_2222};
      vecs[1]  = '{1'b0, 64'hC,  3'd0, 3'd0, 64'd0, 64'hAAAA_BBBB};
      vecs[2]  = '{1'b0, 64'hA,  3'd0, 3'd0, 64'd0, 64'd0};
      vecs[3]  = '{1'b1, 64'h10, 3'd0, 3'd4, 64'h1122_3344_5566_7788, 64'd0};
      vecs[4]  = '{1'b1, 64'h10, 3'd5, 3'd0, 64'd0, 64'h1122_3344_5566_7788};
      vecs[5]  = '{1'b1, 64'h17, 3'd2, 3'd0, 64'd0, 64'h11};
      vecs[6]  = '{1'b1, 64'h10, 3'd1, 3'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FF88};
      vecs[7]  = '{1'b1, 64'h20, 3'd0, 3'd3, 64'hDEAD_BEEF_CAFE_F00D, 64'd0};
      vecs[8]  = '{1'b1, 64'h22, 3'd3, 3'd0, 64'd0, 64'hFFFF_FFFF_FFFF_CAFE};
      vecs[9]  = '{1'b1, 64'h22, 3'd4, 3'd0, 64'd0, 64'hCAFE};
      vecs[10] = '{1'b1, 64'h21, 3'd0, 3'd1, 64'hAB, 64'd0};
      vecs[11] = '{1'b1, 64'h20, 3'd5, 3'd0, 64'd0, 64'h0000_0000_CAFE_AB0D};
      vecs[12] = '{1'b1, 64'h30, 3'd0, 3'd0, 64'h1234, 64'd0};
      vecs[13] = '{1'b1, 64'h28, 3'd5, 3'd4, 64'h55, 64'd0};
      vecs[14] = '{1'b1, 64'h28, 3'd5, 3'd0, 64'd0, 64'h55};
      vecs[15] = '{1'b0, 64'h14, 3'd0, 3'd0, 64'd0, 64'h1122_3344};
      vecs[16] = '{1'b1, 64'h16, 3'd0, 3'd2, 64'h9999, 64'd0};
      vecs[17] = '{1'b1, 64'h10, 3'd5, 3'd0, 64'd0, 64'h9999_3344_5566_7788};
      vecs[18] = '{1'b0, 64'h10, 3'd0, 3'd0, 64'd0, 64'h5566_7788};

      // reset held with both requesters valid
      rst = 1'b1; preload = 1'b1; seed = 32'd0;
      idle_inputs();
      if_req_valid = 1'b1; if_req_addr = 64'h8;
      dm_req_valid = 1'b1; dm_req_addr = 64'h10; dm_req_rd_ctrl = 3'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst ready/valid", 64'({if_req_ready, dm_req_ready, if_rsp_valid, dm_rsp_valid}), 64'd0);
         chk("rst rsp data", dm_rsp_data | {32'd0, if_rsp_data}, 64'd0);
         chk("rst mem_addr", mem_addr, 64'd0);
         chk("rst mem_ctrl", 64'({mem_rd_ctrl, mem_wr_ctrl}), 64'd0);
         chk("rst mem_din", mem_din, 64'd0);
      end
      rst = 1'b0; preload = 1'b0;
      idle_inputs();
      #1 chk("post-rst if_ready", 64'({if_req_ready, dm_req_ready}), 64'b10);

      // directed vectors
      for (int i = 0; i < 19; i++) txn(vecs[i], $sformatf("vec%0d", i));

      // simultaneous IF and DM: DM first, IF on the RESP cycle
      @(negedge clk);
      if_req_valid = 1'b1; if_req_addr = 64'h8;
      dm_req_valid = 1'b1; dm_req_addr = 64'h10; dm_req_rd_ctrl = 3'd5;
      #1 chk("both ready", 64'({dm_req_ready, if_req_ready}), 64'b10);
      @(negedge clk);
      dm_req_valid = 1'b0;
      #1 chk("both access if_ready", 64'(if_req_ready), 64'd0);
      @(negedge clk);
      chk("both dm_rsp_valid", 64'(dm_rsp_valid), 64'd1);
      chk("both dm_rsp_data", dm_rsp_data, 64'h9999_3344_5566_7788);
      chk("both if_ready in RESP", 64'(if_req_ready), 64'd1);
      @(negedge clk);
      if_req_valid = 1'b0;
      chk("both if early", 64'(if_rsp_valid), 64'd0);
      @(negedge clk);
      chk("both if_rsp_valid", 64'(if_rsp_valid), 64'd1);
      chk("both if_rsp_data", 64'(if_rsp_data), 64'h1111_2222);

      // DM continuously valid (no-ops) while IF waits
      @(negedge clk);
      if_req_valid = 1'b1; if_req_addr = 64'h8;
      dm_req_valid = 1'b1; dm_req_addr = 64'h0;
      slots = 0; if_slot = 0;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (if_req_ready || dm_req_ready) slots++;
         if (if_req_ready && if_slot == 0) if_slot = slots;
      end
      idle_inputs();
      chk("starve slots", 64'(slots), 64'd10);
      chk("starve if slot", 64'(if_slot), GUARD ? 64'd5 : 64'd0);
      repeat (4) @(negedge clk);

      // reset during a store's ACCESS cycle
      txn('{1'b1, 64'h18, 3'd0, 3'd4, 64'h0123_4567_89AB_CDEF, 64'd0}, "pre-store");
      @(negedge clk);
      dm_req_valid = 1'b1; dm_req_addr = 64'h18; dm_req_wr_ctrl = 3'd4;
      dm_req_wdata = 64'hFEDC_BA98_7654_3210;
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("midrst mem_wr_ctrl", 64'(mem_wr_ctrl), 64'd0);
      @(negedge clk);
      idle_inputs();
      chk("midrst dm_rsp_valid", 64'(dm_rsp_valid), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post-midrst dm_rsp_valid", 64'(dm_rsp_valid), 64'd0);
      end
      txn('{1'b1, 64'h18, 3'd5, 3'd0, 64'd0, 64'h0123_4567_89AB_CDEF}, "midrst reload");

      // random traffic against the reference model
      @(negedge clk);
      seed = 32'h1234_5678; preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
      sh_init(seed);
      hold_if = 64'd0; hold_dm = 64'h0123_4567_89AB_CDEF;
      acc_prev = 1'b0; starve = 0;
      prev_is_if = 1'b0; prev_addr = 64'd0; prev_wd = 64'd0; prev_rd = 3'd0; prev_wr = 3'd0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         e_if = pq.size() > 0 && pq[0].due == c && pq[0].is_if;
         e_dm = pq.size() > 0 && pq[0].due == c && !pq[0].is_if;
         if (e_if) hold_if = pq[0].data;
         if (e_dm) hold_dm = pq[0].data;
         if (e_if || e_dm) void'(pq.pop_front());
         chk("rnd if_rsp_valid", 64'(if_rsp_valid), 64'(e_if));
         chk("rnd dm_rsp_valid", 64'(dm_rsp_valid), 64'(e_dm));
         chk("rnd if_rsp_data", {32'd0, if_rsp_data}, hold_if);
         chk("rnd dm_rsp_data", dm_rsp_data, hold_dm);
         drv = acc_prev && (prev_is_if || prev_rd != 3'd0 || prev_wr != 3'd0);
         e_addr = !drv ? 64'd0 : prev_is_if ? {prev_addr[63:3], 3'b000} : prev_addr;
         chk("rnd mem_addr", mem_addr, e_addr);
         chk("rnd mem_ctrl", 64'({mem_rd_ctrl, mem_wr_ctrl}),
             !drv ? 64'd0 : prev_is_if ? 64'b101_000 : 64'({prev_rd, prev_wr}));
         chk("rnd mem_din", mem_din, (drv && !prev_is_if) ? prev_wd : 64'd0);
         if_req_valid = 1'($urandom_range(0, 1));
         if_req_addr = {$urandom(), 24'($urandom()), 8'($urandom())};
         dm_req_valid = ($urandom_range(0, 4) < 2);
         op = $urandom_range(0, 10);
         rdv = (op >= 1 && op <= 5) ? 3'(op) : (op == 10) ? 3'd5 : 3'd0;
         wrv = (op >= 6 && op <= 9) ? 3'(op - 5) : (op == 10) ? 3'($urandom_range(1, 4)) : 3'd0;
         al = (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 : (op == 8) ? 4 : 8;
         a8 = 8'($urandom()) & ~8'(al - 1);
         dm_req_addr = {$urandom(), 24'($urandom()), a8};
         dm_req_rd_ctrl = rdv; dm_req_wr_ctrl = wrv;
         dm_req_wdata = {$urandom(), $urandom()};
         #1;
         win_if = !dm_req_valid || (GUARD && starve == STARVE_MAX && if_req_valid);
         p_if_rdy = !acc_prev && win_if;
         p_dm_rdy = !acc_prev && !win_if;
         chk("rnd if_req_ready", 64'(if_req_ready), 64'(p_if_rdy));
         chk("rnd dm_req_ready", 64'(dm_req_ready), 64'(p_dm_rdy));
         a_if = if_req_valid && p_if_rdy;
         a_dm = dm_req_valid && p_dm_rdy;
         if (a_if) begin
            pq.push_back('{1'b1, ref_if(if_req_addr[7:0]), c + 2});
            prev_is_if = 1'b1; prev_addr = if_req_addr;
         end else if (a_dm) begin
            ref_dm(dm_req_addr[7:0], rdv, wrv, dm_req_wdata, r);
            pq.push_back('{1'b0, r, c + 2});
            prev_is_if = 1'b0; prev_addr = dm_req_addr;
            prev_rd = rdv; prev_wr = wrv; prev_wd = dm_req_wdata;
         end
         if (a_if || a_dm) starve = (a_dm && if_req_valid) ? starve + 1 : 0;
         acc_prev = a_if || a_dm;
      end
      idle_inputs();
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
